cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 32, result and PC width.
REQ-002 SHALL have parameter TAG_W, default 4, ROB tag width; tag 0 is the null tag.
REQ-003 SHALL have parameter DEPTH, default 2, per-requester queue depth (power of two, >=2).
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rollback_in, input, 1, synchronous flush request.
REQ-007 SHALL have ports alu_valid_in (in, 1), alu_ready_out (out, 1), alu_result_in (in, WORD_W), alu_tag_in (in, TAG_W), alu_new_pc_in (in, WORD_W): the ALU broadcast request.
REQ-008 SHALL have ports lsb_valid_in (in, 1), lsb_ready_out (out, 1), lsb_result_in (in, WORD_W), lsb_tag_in (in, TAG_W): the LSB broadcast request.
REQ-009 SHALL have ports cdb_valid_out (out, 1), cdb_result_out (out, WORD_W), cdb_tag_out (out, TAG_W), cdb_new_pc_out (out, WORD_W), cdb_src_out (out, 1; 0=ALU, 1=LSB): the single shared common data bus.

Function
REQ-010 SHALL keep one FIFO of DEPTH entries per requester; a beat is accepted when valid_in and ready_out are both high at a rising edge.
REQ-011 SHALL drive each ready_out high iff that FIFO is not full, from registered state only; a pop in the same cycle does not raise ready_out.
REQ-012 SHALL accept and silently discard a beat whose tag is 0.
REQ-013 SHALL, each cycle in which at least one FIFO is non-empty, grant exactly one head entry, pop it, and register it onto the cdb outputs at the next edge.
REQ-014 SHALL give minimum latency of one edge: a beat accepted at edge E into an empty, uncontested FIFO appears with cdb_valid_out=1 after edge E+1.
REQ-015 SHALL hold cdb_valid_out high for exactly one cycle per granted beat and drive it low in any cycle with no grant.
REQ-016 SHALL drive cdb_new_pc_out from the ALU entry for ALU grants and 0 for LSB grants.
REQ-017 SHALL preserve per-requester order; no beat is dropped or duplicated except under REQ-012 or rollback.
REQ-018 SHALL, with both FIFOs full and granted continuously, permit push on each side once that side's occupancy has dropped below DEPTH.
REQ-019 SHALL, on rollback_in high at an edge, empty both FIFOs, ignore inputs presented that cycle, drive cdb_valid_out low after that edge, and restore the arbitration pointer to its reset value.
REQ-020 SHALL let rollback_in take precedence over every simultaneous push and grant.

Reset
REQ-021 SHALL, on rst_n low, immediately and regardless of clk clear both FIFOs and set the pointer to ALU-first.
REQ-022 SHALL, on rst_n low, set cdb_valid_out=0, cdb_result_out=0, cdb_tag_out=0, cdb_new_pc_out=0 and cdb_src_out=0.
REQ-023 SHALL, on rst_n low, drive alu_ready_out=1 and lsb_ready_out=1.
REQ-024 SHALL, when rst_n is asserted mid-operation, lose all queued beats and register no grant until rst_n has been high for one rising edge.

Configuration
REQ-025 SHALL, with CDB_ARB_RR_EN defined, use round-robin: when both FIFOs are non-empty, grant the side not granted last; a pending requester waits at most one grant.
REQ-026 SHALL, without CDB_ARB_RR_EN, use fixed priority with ALU always winning, so LSB is granted only when the ALU FIFO is empty.

Verification
REQ-027 SHALL cover: ALU beat tag=3, result=0x11, new_pc=0x104 at edge 1 -> cdb_valid after edge 2 with tag=3, src=0, new_pc=0x104.
REQ-028 SHALL cover: ALU tag=2 and LSB tag=5 both accepted at edge 1, RR_EN -> ALU tag 2 after edge 2, LSB tag 5 after edge 3; then both again -> LSB first.
REQ-029 SHALL cover: ALU valid every cycle for 8 cycles, LSB one beat, no RR_EN -> LSB granted only after the ALU FIFO drains; with RR_EN -> LSB granted within 2 cycles.
REQ-030 SHALL cover: fill LSB FIFO (2 beats) while the CDB is blocked by ALU traffic -> lsb_ready_out=0 until the first LSB pop edge, then 1.
REQ-031 SHALL cover: 2 queued beats per side, rollback_in pulse -> cdb_valid_out=0 next cycle, both ready=1, no stale beat ever emitted.
REQ-032 SHALL cover: rst_n low asynchronously between edges with 3 queued beats -> outputs zero immediately, no further grants.

Source files
------------

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Arbitrates two result producers (ALU and load/store buffer) onto one shared
// common data bus. Each producer feeds its own small FIFO; every cycle in which
// any FIFO holds an entry, exactly one head entry is popped and registered onto
// the cdb outputs at the next rising edge.
//
// Build option:
//   CDB_ARB_RR_EN  defined   -> round-robin between the two FIFOs when both
//                               hold entries.
//                  undefined -> fixed priority, ALU always wins.
//
// Parameters:
//   WORD_W  result / PC width
//   TAG_W   ROB tag width; tag 0 is the null tag and is dropped on entry
//   DEPTH   per-requester FIFO depth (power of two, >= 2)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rollback_in         synchronous flush of both FIFOs and the arbitration
//                       pointer
//   alu_valid_in, alu_ready_out, alu_result_in, alu_tag_in, alu_new_pc_in
//                       ALU broadcast request
//   lsb_valid_in, lsb_ready_out, lsb_result_in, lsb_tag_in
//                       LSB broadcast request
//   cdb_valid_out, cdb_result_out, cdb_tag_out, cdb_new_pc_out, cdb_src_out
//                       registered common data bus (src: 0 = ALU, 1 = LSB)
//
// Handshake: a beat transfers on a rising edge where valid_in and ready_out are
// both high. ready_out depends only on registered FIFO occupancy, so it never
// combinationally follows valid_in or a same-cycle pop. valid_in may be raised
// without waiting for ready_out; a beat offered while ready_out is low is not
// taken and must be held (or re-offered) by the producer.
// -----------------------------------------------------------------------------

// Single-clock FIFO used once per requester. flush has precedence over push
// and pop. Push is refused whenever the FIFO is full, even if a pop happens in
// the same cycle, so the producer-facing ready stays purely registered.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous clear of all entries
//   push         write push_data at the tail (ignored when full)
//   push_data    entry to write
//   pop          remove the head entry (ignored when empty)
//   head_data    current head entry (undefined content when empty)
//   empty, full  registered occupancy flags
module cdb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign head_data = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module cdb_arbiter #(
    parameter int WORD_W = 32,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rollback_in,

    input  logic              alu_valid_in,
    output logic              alu_ready_out,
    input  logic [WORD_W-1:0] alu_result_in,
    input  logic [TAG_W-1:0]  alu_tag_in,
    input  logic [WORD_W-1:0] alu_new_pc_in,

    input  logic              lsb_valid_in,
    output logic              lsb_ready_out,
    input  logic [WORD_W-1:0] lsb_result_in,
    input  logic [TAG_W-1:0]  lsb_tag_in,

    output logic              cdb_valid_out,
    output logic [WORD_W-1:0] cdb_result_out,
    output logic [TAG_W-1:0]  cdb_tag_out,
    output logic [WORD_W-1:0] cdb_new_pc_out,
    output logic              cdb_src_out
);
    // ALU entry = {tag, result, new_pc}; LSB entry = {tag, result}.
    localparam int ALU_W = TAG_W + 2 * WORD_W;
    localparam int LSB_W = TAG_W + WORD_W;

    logic              alu_full;
    logic              alu_empty;
    logic              lsb_full;
    logic              lsb_empty;
    logic              alu_push;
    logic              lsb_push;
    logic              grant_alu;
    logic              grant_lsb;
    logic              alu_pending;
    logic              lsb_pending;
    logic [ALU_W-1:0]  alu_head;
    logic [LSB_W-1:0]  lsb_head;

    logic [TAG_W-1:0]  alu_head_tag;
    logic [WORD_W-1:0] alu_head_result;
    logic [WORD_W-1:0] alu_head_pc;
    logic [TAG_W-1:0]  lsb_head_tag;
    logic [WORD_W-1:0] lsb_head_result;

    assign alu_ready_out = !alu_full;
    assign lsb_ready_out = !lsb_full;

    // A null-tag beat completes its handshake but is never stored. Beats
    // offered in a rollback cycle are ignored outright.
    assign alu_push = alu_valid_in && alu_ready_out && (alu_tag_in != '0) && !rollback_in;
    assign lsb_push = lsb_valid_in && lsb_ready_out && (lsb_tag_in != '0) && !rollback_in;

    assign alu_pending = !alu_empty;
    assign lsb_pending = !lsb_empty;

    cdb_fifo #(
        .W     (ALU_W),
        .DEPTH (DEPTH)
    ) u_alu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (rollback_in),
        .push      (alu_push),
        .push_data ({alu_tag_in, alu_result_in, alu_new_pc_in}),
        .pop       (grant_alu),
        .head_data (alu_head),
        .empty     (alu_empty),
        .full      (alu_full)
    );

    cdb_fifo #(
        .W     (LSB_W),
        .DEPTH (DEPTH)
    ) u_lsb_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (rollback_in),
        .push      (lsb_push),
        .push_data ({lsb_tag_in, lsb_result_in}),
        .pop       (grant_lsb),
        .head_data (lsb_head),
        .empty     (lsb_empty),
        .full      (lsb_full)
    );

    assign {alu_head_tag, alu_head_result, alu_head_pc} = alu_head;
    assign {lsb_head_tag, lsb_head_result}              = lsb_head;

`ifdef CDB_ARB_RR_EN
    // prefer_lsb selects the winner only when both FIFOs hold entries, and only
    // such contested grants move it. An uncontested grant leaves it alone, so
    // the side that lost the last contest is the one that wins the next.
    logic prefer_lsb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer_lsb <= 1'b0;
        end else if (rollback_in) begin
            prefer_lsb <= 1'b0;
        end else if (alu_pending && lsb_pending) begin
            prefer_lsb <= grant_alu;
        end
    end
`endif

    always_comb begin
        grant_alu = 1'b0;
        grant_lsb = 1'b0;
        if (!rollback_in) begin
`ifdef CDB_ARB_RR_EN
            if (alu_pending && lsb_pending) begin
                grant_alu = !prefer_lsb;
                grant_lsb = prefer_lsb;
            end else begin
                grant_alu = alu_pending;
                grant_lsb = lsb_pending;
            end
`else
            grant_alu = alu_pending;
            grant_lsb = lsb_pending && !alu_pending;
`endif
        end
    end

    // Bus register: one cycle of valid per granted beat. Payload fields are
    // held when idle and only meaningful while cdb_valid_out is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_out  <= 1'b0;
            cdb_result_out <= '0;
            cdb_tag_out    <= '0;
            cdb_new_pc_out <= '0;
            cdb_src_out    <= 1'b0;
        end else if (rollback_in) begin
            cdb_valid_out  <= 1'b0;
        end else if (grant_alu) begin
            cdb_valid_out  <= 1'b1;
            cdb_result_out <= alu_head_result;
            cdb_tag_out    <= alu_head_tag;
            cdb_new_pc_out <= alu_head_pc;
            cdb_src_out    <= 1'b0;
        end else if (grant_lsb) begin
            cdb_valid_out  <= 1'b1;
            cdb_result_out <= lsb_head_result;
            cdb_tag_out    <= lsb_head_tag;
            cdb_new_pc_out <= '0;
            cdb_src_out    <= 1'b1;
        end else begin
            cdb_valid_out  <= 1'b0;
        end
    end

    // At most one head may be granted, and only from a FIFO holding an entry.
    a_one_grant : assert property (@(posedge clk) disable iff (!rst_n)
        !(grant_alu && grant_lsb));
    a_alu_grant_pending : assert property (@(posedge clk) disable iff (!rst_n)
        grant_alu |-> alu_pending);
    a_lsb_grant_pending : assert property (@(posedge clk) disable iff (!rst_n)
        grant_lsb |-> lsb_pending);
endmodule

// File: tb/tb_cdb_arbiter.sv
`timescale 1ns/1ps
module tb_cdb_arbiter;
    localparam int WORD_W = 32;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 2;
    localparam int ENT_W  = TAG_W + 2 * WORD_W;
`ifdef CDB_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              rollback_in;
    logic              alu_valid_in;
    logic              alu_ready_out;
    logic [WORD_W-1:0] alu_result_in;
    logic [TAG_W-1:0]  alu_tag_in;
    logic [WORD_W-1:0] alu_new_pc_in;
    logic              lsb_valid_in;
    logic              lsb_ready_out;
    logic [WORD_W-1:0] lsb_result_in;
    logic [TAG_W-1:0]  lsb_tag_in;
    logic              cdb_valid_out;
    logic [WORD_W-1:0] cdb_result_out;
    logic [TAG_W-1:0]  cdb_tag_out;
    logic [WORD_W-1:0] cdb_new_pc_out;
    logic              cdb_src_out;

    int checks   = 0;
    int failures = 0;

    cdb_arbiter #(
        .WORD_W (WORD_W),
        .TAG_W  (TAG_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rollback_in    (rollback_in),
        .alu_valid_in   (alu_valid_in),
        .alu_ready_out  (alu_ready_out),
        .alu_result_in  (alu_result_in),
        .alu_tag_in     (alu_tag_in),
        .alu_new_pc_in  (alu_new_pc_in),
        .lsb_valid_in   (lsb_valid_in),
        .lsb_ready_out  (lsb_ready_out),
        .lsb_result_in  (lsb_result_in),
        .lsb_tag_in     (lsb_tag_in),
        .cdb_valid_out  (cdb_valid_out),
        .cdb_result_out (cdb_result_out),
        .cdb_tag_out    (cdb_tag_out),
        .cdb_new_pc_out (cdb_new_pc_out),
        .cdb_src_out    (cdb_src_out)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Queues of pending beats ({tag, result, new_pc}) per requester, plus the
    // round-robin preference and the expected bus contents after each edge.
    logic [ENT_W-1:0]  alu_exp_q[$];
    logic [ENT_W-1:0]  lsb_exp_q[$];
    bit                m_prefer_lsb;
    logic              m_valid;
    logic              m_src;
    logic [TAG_W-1:0]  m_tag;
    logic [WORD_W-1:0] m_res;
    logic [WORD_W-1:0] m_pc;

    task automatic reset_model();
        alu_exp_q.delete();
        lsb_exp_q.delete();
        m_prefer_lsb = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic av, input logic [TAG_W-1:0] at,
                              input logic [WORD_W-1:0] ar, input logic [WORD_W-1:0] ap,
                              input logic lv, input logic [TAG_W-1:0] lt,
                              input logic [WORD_W-1:0] lr, input logic rb);
        logic [ENT_W-1:0] e;
        bit a_rdy;
        bit l_rdy;
        bit take_alu;
        bit take_lsb;
        if (rb) begin
            reset_model();
            return;
        end
        a_rdy = alu_exp_q.size() < DEPTH;
        l_rdy = lsb_exp_q.size() < DEPTH;
        take_alu = 1'b0;
        take_lsb = 1'b0;
        if (alu_exp_q.size() > 0 && lsb_exp_q.size() > 0) begin
            if (RR_MODE && m_prefer_lsb) take_lsb = 1'b1;
            else                         take_alu = 1'b1;
            if (RR_MODE) m_prefer_lsb = take_alu;
        end else if (alu_exp_q.size() > 0) begin
            take_alu = 1'b1;
        end else if (lsb_exp_q.size() > 0) begin
            take_lsb = 1'b1;
        end
        m_valid = take_alu || take_lsb;
        if (take_alu) begin
            e = alu_exp_q.pop_front();
            m_src = 1'b0;
            {m_tag, m_res, m_pc} = e;
        end else if (take_lsb) begin
            e = lsb_exp_q.pop_front();
            m_src = 1'b1;
            {m_tag, m_res, m_pc} = e;
        end
        if (av && a_rdy && at != '0) alu_exp_q.push_back({at, ar, ap});
        if (lv && l_rdy && lt != '0) lsb_exp_q.push_back({lt, lr, {WORD_W{1'b0}}});
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive at the falling edge, advance the model at the rising edge, and
    // compare 1 ns later.
    task automatic step(input logic av, input logic [TAG_W-1:0] at,
                        input logic [WORD_W-1:0] ar, input logic [WORD_W-1:0] ap,
                        input logic lv, input logic [TAG_W-1:0] lt,
                        input logic [WORD_W-1:0] lr, input logic rb);
        @(negedge clk);
        alu_valid_in  = av;
        alu_tag_in    = at;
        alu_result_in = ar;
        alu_new_pc_in = ap;
        lsb_valid_in  = lv;
        lsb_tag_in    = lt;
        lsb_result_in = lr;
        rollback_in   = rb;
        @(posedge clk);
        model_edge(av, at, ar, ap, lv, lt, lr, rb);
        #1;
        check("model_valid", cdb_valid_out, m_valid);
        if (m_valid) begin
            check("model_src", cdb_src_out, m_src);
            check("model_tag", cdb_tag_out, m_tag);
            check("model_result", cdb_result_out, m_res);
            check("model_new_pc", cdb_new_pc_out, m_pc);
        end
        check("model_alu_ready", alu_ready_out, alu_exp_q.size() < DEPTH);
        check("model_lsb_ready", lsb_ready_out, lsb_exp_q.size() < DEPTH);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // Asserts rst_n between clock edges and checks the outputs react at once.
    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        alu_valid_in = 1'b0;
        lsb_valid_in = 1'b0;
        rollback_in  = 1'b0;
        rst_n = 1'b0;
        #1;
        check({name, "_valid"}, cdb_valid_out, 1'b0);
        check({name, "_result"}, cdb_result_out, '0);
        check({name, "_tag"}, cdb_tag_out, '0);
        check({name, "_new_pc"}, cdb_new_pc_out, '0);
        check({name, "_src"}, cdb_src_out, 1'b0);
        check({name, "_alu_ready"}, alu_ready_out, 1'b1);
        check({name, "_lsb_ready"}, lsb_ready_out, 1'b1);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic              av;
        logic [TAG_W-1:0]  at;
        logic [WORD_W-1:0] ar;
        logic [WORD_W-1:0] ap;
        logic              lv;
        logic [TAG_W-1:0]  lt;
        logic [WORD_W-1:0] lr;
        logic              rb;
        logic              ev;
        logic              es;
        logic [TAG_W-1:0]  et;
        logic [WORD_W-1:0] er;
        logic [WORD_W-1:0] ep;
        logic              ear;
        logic              elr;
    } vec_t;

    localparam int NV = 16;
    vec_t vec [NV];

    initial begin
        int alu_emits;
        int alu_before_lsb;
        bit lsb_seen;

        rst_n         = 1'b0;
        rollback_in   = 1'b0;
        alu_valid_in  = 1'b0;
        alu_tag_in    = '0;
        alu_result_in = '0;
        alu_new_pc_in = '0;
        lsb_valid_in  = 1'b0;
        lsb_tag_in    = '0;
        lsb_result_in = '0;

        //              av    at     ar       ap        lv    lt     lr       rb     ev    es    et     er       ep        ear   elr
        vec[0]  = '{1'b1, 4'd3, 32'h11, 32'h104, 1'b0, 4'd0, 32'h0,  1'b0, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   1'b1, 1'b1};
        vec[1]  = '{1'b0, 4'd0, 32'h0,  32'h0,   1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 1'b0, 4'd3, 32'h11, 32'h104, 1'b1, 1'b1};
        vec[2]  = '{1'b0, 4'd0, 32'h0,  32'h0,   1'b0, 4'd0, 32'h0,  1'b0, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   1'b1, 1'b1};
        vec[3]  = '{1'b1, 4'd2, 32'h22, 32'h200, 1'b1, 4'd5, 32'h55, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   1'b1, 1'b1};
        vec[4]  = '{1'b0, 4'd0, 32'h0,  32'h0,   1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 1'b0, 4'd2, 32'h22, 32'h200, 1'b1, 1'b1};
        vec[5]  = '{1'b0, 4'd0, 32'h0,  32'h0,   1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 1'b1, 4'd5, 32'h55, 32'h0,   1'b1, 1'b1};
        vec[6]  = '{1'b0, 4'd0, 32'h0,  32'h0,   1'b0, 4'd0, 32'h0,  1'b0, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   1'b1, 1'b1};
        vec[7]  = '{1'b1, 4'd0, 32'h99, 32'h300, 1'b0, 4'd0, 32'h0,  1'b0, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   1'b1, 1'b1};
        vec[8]  = '{1'b0, 4'd0, 32'h0,  32'h0,   1'b0, 4'd0, 32'h0,  1'b0, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   1'b1, 1'b1};
        vec[9]  = '{1'b0, 4'd0, 32'h0,  32'h0,   1'b1, 4'd7, 32'h77, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   1'b1, 1'b1};
        vec[10] = '{1'b0, 4'd0, 32'h0,  32'h0,   1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 1'b1, 4'd7, 32'h77, 32'h0,   1'b1, 1'b1};
        vec[11] = '{1'b1, 4'd1, 32'hAA, 32'h10,  1'b1, 4'd6, 32'h66, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   1'b1, 1'b1};
        vec[12] = '{1'b0, 4'd0, 32'h0,  32'h0,   1'b0, 4'd0, 32'h0,  1'b0, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   1'b1, 1'b1};
        vec[13] = '{1'b1, 4'd9, 32'h5,  32'h8,   1'b1, 4'd0, 32'h44, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   1'b1, 1'b1};
        vec[14] = '{1'b0, 4'd0, 32'h0,  32'h0,   1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 1'b0, 4'd9, 32'h5,  32'h8,   1'b1, 1'b1};
        vec[15] = '{1'b0, 4'd0, 32'h0,  32'h0,   1'b0, 4'd0, 32'h0,  1'b0, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   1'b1, 1'b1};

        // Reset state while rst_n is held low from time zero.
        #1;
        check("por_valid", cdb_valid_out, 1'b0);
        check("por_result", cdb_result_out, '0);
        check("por_tag", cdb_tag_out, '0);
        check("por_new_pc", cdb_new_pc_out, '0);
        check("por_src", cdb_src_out, 1'b0);
        check("por_alu_ready", alu_ready_out, 1'b1);
        check("por_lsb_ready", lsb_ready_out, 1'b1);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven directed vectors.
        for (int i = 0; i < NV; i++) begin
            step(vec[i].av, vec[i].at, vec[i].ar, vec[i].ap,
                 vec[i].lv, vec[i].lt, vec[i].lr, vec[i].rb);
            check($sformatf("vec%0d_valid", i), cdb_valid_out, vec[i].ev);
            if (vec[i].ev) begin
                check($sformatf("vec%0d_src", i), cdb_src_out, vec[i].es);
                check($sformatf("vec%0d_tag", i), cdb_tag_out, vec[i].et);
                check($sformatf("vec%0d_result", i), cdb_result_out, vec[i].er);
                check($sformatf("vec%0d_new_pc", i), cdb_new_pc_out, vec[i].ep);
            end
            check($sformatf("vec%0d_alu_ready", i), alu_ready_out, vec[i].ear);
            check($sformatf("vec%0d_lsb_ready", i), lsb_ready_out, vec[i].elr);
        end

        // Simultaneous requests, twice in a row.
        do_reset("rst_a");
        step(1'b1, 4'd2, 32'h102, 32'h40, 1'b1, 4'd5, 32'h205, 1'b0);
        idle();
        check("dual1_src", cdb_src_out, 1'b0);
        check("dual1_tag", cdb_tag_out, 4'd2);
        idle();
        check("dual1b_src", cdb_src_out, 1'b1);
        check("dual1b_tag", cdb_tag_out, 4'd5);
        step(1'b1, 4'd6, 32'h106, 32'h44, 1'b1, 4'd7, 32'h207, 1'b0);
        idle();
`ifdef CDB_ARB_RR_EN
        check("dual2_src", cdb_src_out, 1'b1);
        check("dual2_tag", cdb_tag_out, 4'd7);
        idle();
        check("dual2b_src", cdb_src_out, 1'b0);
        check("dual2b_tag", cdb_tag_out, 4'd6);
`else
        check("dual2_src", cdb_src_out, 1'b0);
        check("dual2_tag", cdb_tag_out, 4'd6);
        idle();
        check("dual2b_src", cdb_src_out, 1'b1);
        check("dual2b_tag", cdb_tag_out, 4'd7);
`endif

        // ALU streaming for 8 cycles with one LSB beat.
        do_reset("rst_b");
        alu_emits = 0;
        alu_before_lsb = -1;
        for (int c = 0; c < 20; c++) begin
            step(c < 8, TAG_W'((c % 7) + 1), WORD_W'(c), WORD_W'(c * 4),
                 c == 0, 4'hC, 32'hCC, 1'b0);
            if (cdb_valid_out) begin
                if (!cdb_src_out) alu_emits++;
                else if (alu_before_lsb < 0) alu_before_lsb = alu_emits;
            end
        end
`ifdef CDB_ARB_RR_EN
        check("stream_alu_before_lsb", alu_before_lsb, 1);
`else
        check("stream_alu_before_lsb", alu_before_lsb, 8);
`endif

        // LSB FIFO filled while ALU traffic holds the bus.
        do_reset("rst_c");
        lsb_seen = 1'b0;
        for (int c = 0; c < 14; c++) begin
            step(c < 5, TAG_W'(c + 1), WORD_W'(32'h300 + c), WORD_W'(c * 8),
                 c < 2, TAG_W'(8 + c), WORD_W'(32'h400 + c), 1'b0);
            if (!lsb_seen) begin
                if (cdb_valid_out && cdb_src_out) begin
                    lsb_seen = 1'b1;
                    check("fill_ready_at_pop", lsb_ready_out, 1'b1);
                end else if (c >= 1) begin
                    check("fill_ready_blocked", lsb_ready_out, 1'b0);
                end
            end
        end
        check("fill_lsb_granted", lsb_seen, 1'b1);

        // Rollback with beats queued on both sides.
        do_reset("rst_d");
        for (int c = 0; c < 3; c++) begin
            step(1'b1, TAG_W'(c + 1), WORD_W'(32'h500 + c), WORD_W'(32'h600 + c),
                 1'b1, TAG_W'(c + 4), WORD_W'(32'h700 + c), 1'b0);
        end
        step(1'b1, 4'hE, 32'hEE, 32'hE0, 1'b1, 4'hF, 32'hFF, 1'b1);
        check("rb_valid", cdb_valid_out, 1'b0);
        check("rb_alu_ready", alu_ready_out, 1'b1);
        check("rb_lsb_ready", lsb_ready_out, 1'b1);
        for (int c = 0; c < 6; c++) begin
            idle();
            check("rb_no_stale", cdb_valid_out, 1'b0);
        end

        // Asynchronous reset mid-operation with three beats queued.
        do_reset("rst_e");
        step(1'b1, 4'd1, 32'h801, 32'h900, 1'b1, 4'd2, 32'h802, 1'b0);
        step(1'b1, 4'd3, 32'h803, 32'h904, 1'b1, 4'd4, 32'h804, 1'b0);
        check("async_pre_valid", cdb_valid_out, 1'b1);
        do_reset("async_rst");
        for (int c = 0; c < 5; c++) begin
            idle();
            check("async_no_grant", cdb_valid_out, 1'b0);
        end

        // Randomized traffic against the model.
        do_reset("rst_f");
        for (int c = 0; c < 500; c++) begin
            step(1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 15)),
                 WORD_W'($urandom), WORD_W'($urandom),
                 1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 15)),
                 WORD_W'($urandom), $urandom_range(0, 39) == 0);
        end
        for (int c = 0; c < 8; c++) idle();
        check("drain_alu_empty", alu_exp_q.size(), 0);
        check("drain_lsb_empty", lsb_exp_q.size(), 0);

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
